// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path definitions: default character width, FIFO depth
// and the pointer-width derivation used by the receive FIFO.
package uart_rx_fifo_pkg;

    localparam int unsigned UART_DATA_WIDTH = 8;
    localparam int unsigned UART_FIFO_DEPTH = 8;

    // Pointer width for a power-of-two depth; COUNT needs one extra bit to reach DEPTH.
    function automatic int unsigned fifo_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned UART_FIFO_PTR_W = fifo_ptr_w(UART_FIFO_DEPTH);

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive-FIFO bus: UART receiver write strobe, consumer pop handshake and flags.
// OVERRUN/OVERRUN_CLR exist only when UART_RX_FIFO_OVERRUN_EN is defined.
interface uart_rx_fifo_if #(
    parameter int unsigned DATA_WIDTH = uart_rx_fifo_pkg::UART_DATA_WIDTH,
    parameter int unsigned DEPTH      = uart_rx_fifo_pkg::UART_FIFO_DEPTH
);
    import uart_rx_fifo_pkg::*;

    localparam int unsigned CNT_W = fifo_ptr_w(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] P_DATA_IN;
    logic                  DATA_VALID_IN;
    logic                  RD_EN;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  RD_VALID;
    logic                  EMPTY;
    logic                  FULL;
    logic [CNT_W-1:0]      COUNT;
`ifdef UART_RX_FIFO_OVERRUN_EN
    logic                  OVERRUN_CLR;
    logic                  OVERRUN;

    modport slave (
        input  P_DATA_IN, DATA_VALID_IN, RD_EN, OVERRUN_CLR,
        output RD_DATA, RD_VALID, EMPTY, FULL, COUNT, OVERRUN
    );
    modport master (
        output P_DATA_IN, DATA_VALID_IN, RD_EN, OVERRUN_CLR,
        input  RD_DATA, RD_VALID, EMPTY, FULL, COUNT, OVERRUN
    );
`else
    modport slave (
        input  P_DATA_IN, DATA_VALID_IN, RD_EN,
        output RD_DATA, RD_VALID, EMPTY, FULL, COUNT
    );
    modport master (
        output P_DATA_IN, DATA_VALID_IN, RD_EN,
        input  RD_DATA, RD_VALID, EMPTY, FULL, COUNT
    );
`endif

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// Receive-FIFO storage: one synchronous write port, one registered read port.
// The array itself is not reset; only the read register is.
module uart_rx_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_W     = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read returns the pre-write contents when both ports hit the same slot (full FIFO).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: pointers, occupancy count and flags around uart_rx_fifo_mem.
// Optional overrun flag enabled by defining UART_RX_FIFO_OVERRUN_EN.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned DEPTH      = UART_FIFO_DEPTH   // power of two, 2..64
) (
    input  logic          CLK_UART_RX_FIFO,
    input  logic          RST_UART_RX_FIFO,
    uart_rx_fifo_if.slave bus
);

    localparam int unsigned PTR_W = fifo_ptr_w(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             rd_valid_q;
    logic             rd_acc_c;
    logic             wr_acc_c;

    // A read frees a slot this cycle, so a full FIFO still accepts a write alongside it.
    always_comb begin
        rd_acc_c = bus.RD_EN && !empty_q;
        wr_acc_c = bus.DATA_VALID_IN && (!full_q || rd_acc_c);
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_acc_c);
        count_d  = count_q + CNT_W'(wr_acc_c) - CNT_W'(rd_acc_c);
        empty_d  = (count_d == '0);
        full_d   = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge CLK_UART_RX_FIFO or negedge RST_UART_RX_FIFO) begin
        if (!RST_UART_RX_FIFO) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            rd_valid_q <= rd_acc_c;
        end
    end

    uart_rx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk_i      (CLK_UART_RX_FIFO),
        .rst_ni     (RST_UART_RX_FIFO),
        .wr_en_i    (wr_acc_c),
        .wr_addr_i  (wr_ptr_q),
        .wr_data_i  (bus.P_DATA_IN),
        .rd_en_i    (rd_acc_c),
        .rd_addr_i  (rd_ptr_q),
        .rd_data_o  (bus.RD_DATA)
    );

    assign bus.RD_VALID = rd_valid_q;
    assign bus.COUNT    = count_q;
    assign bus.EMPTY    = empty_q;
    assign bus.FULL     = full_q;

`ifdef UART_RX_FIFO_OVERRUN_EN
    logic overrun_q, overrun_d;

    // A dropped character wins over a simultaneous clear.
    always_comb begin
        overrun_d = overrun_q;
        if (bus.DATA_VALID_IN && !wr_acc_c) begin
            overrun_d = 1'b1;
        end else if (bus.OVERRUN_CLR) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_UART_RX_FIFO or negedge RST_UART_RX_FIFO) begin
        if (!RST_UART_RX_FIFO) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign bus.OVERRUN = overrun_q;
`endif

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001: Parameter DATA_WIDTH, default 8, width of each received character.
REQ-002: Parameter DEPTH, default 8, number of entries; SHALL be a power of two, 2..64.
REQ-003: Port CLK_UART_RX_FIFO  input  1  sole clock, rising-edge active, same clock as the UART receiver.
REQ-004: Port RST_UART_RX_FIFO  input  1  reset, asynchronous assertion, active-low.
REQ-005: Port P_DATA_IN  input  DATA_WIDTH  parallel character from the UART receiver.
REQ-006: Port DATA_VALID_IN  input  1  one-cycle strobe; P_DATA_IN is valid in that cycle.
REQ-007: Port RD_EN  input  1  pop request from the consumer.
REQ-008: Port RD_DATA  output  DATA_WIDTH  registered popped character.
REQ-009: Port RD_VALID  output  1  one-cycle strobe; RD_DATA is valid in that cycle.
REQ-010: Ports EMPTY and FULL  output  1 each  occupancy flags.
REQ-011: Port COUNT  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-012: Write accepted when DATA_VALID_IN=1 and (FULL=0 or a read is accepted in the same cycle); P_DATA_IN stored at write pointer.
REQ-013: Read accepted when RD_EN=1 and EMPTY=0; RD_DATA and RD_VALID update on the next rising edge (latency 1).
REQ-014: RD_EN while EMPTY=1 SHALL be ignored: RD_VALID stays 0, RD_DATA holds its value.
REQ-015: No fall-through: a write and a read in the same cycle with EMPTY=1 SHALL accept only the write.
REQ-016: Simultaneous accepted read and write SHALL leave COUNT unchanged; FULL stays 1 when full.
REQ-017: Read and write pointers SHALL wrap from DEPTH-1 to 0; ordering is strictly first-in first-out.
REQ-018: COUNT, EMPTY, FULL are registered and reflect the state after the last edge; EMPTY=(COUNT==0), FULL=(COUNT==DEPTH).
REQ-019: DATA_VALID_IN with FULL=1 and no accepted read SHALL drop the character; stored contents are unaffected.
REQ-020: RD_DATA SHALL hold the last popped value until the next accepted read.

Reset
REQ-021: Reset low SHALL immediately clear both pointers and COUNT, set EMPTY=1, FULL=0, RD_VALID=0, RD_DATA=0.
REQ-022: Reset mid-operation SHALL discard all stored characters; storage array contents need not be cleared.
REQ-023: First write or read SHALL be accepted on the first rising edge after reset deassertion.

Configuration
REQ-024: Macro UART_RX_FIFO_OVERRUN_EN SHALL control overrun reporting.
REQ-025: With the macro defined: input OVERRUN_CLR (1 bit) and output OVERRUN (1 bit) exist; OVERRUN sets on any dropped character (REQ-019), stays set until OVERRUN_CLR=1 at a rising edge; set takes priority over a simultaneous clear; reset value 0.
REQ-026: Without the macro: OVERRUN and OVERRUN_CLR ports are absent; drops are silent; all other behaviour identical.

Structure
REQ-027: Shared UART definitions package holds DATA_WIDTH default (8), DEPTH default (8) and the pointer-width derivation constant.
REQ-028: Storage SHALL be a separate sub-module uart_rx_fifo_mem: synchronous write, registered read, one write and one read port, no reset on the array.
REQ-029: Pointers, COUNT, flags and the overrun logic stay in uart_rx_fifo.

Verification (DEPTH=8, DATA_WIDTH=8)
REQ-030: Reset, then one DATA_VALID_IN strobe with 0x39 -> next cycle COUNT=1, EMPTY=0; RD_EN one cycle -> RD_VALID=1 with RD_DATA=0x39 one cycle later, EMPTY=1.
REQ-031: Write 0x01..0x08 -> FULL=1, COUNT=8; strobe 0xAA -> dropped, OVERRUN=1 (macro on); pop 8 -> RD_DATA 0x01..0x08 in order, 0xAA never appears.
REQ-032: With COUNT=8, write 0x55 and RD_EN in the same cycle -> RD_DATA=0x01, COUNT stays 8, FULL stays 1, 0x55 popped last; OVERRUN unchanged.
REQ-033: With EMPTY=1, write 0x77 and RD_EN in the same cycle -> RD_VALID=0, COUNT=1; next RD_EN -> RD_DATA=0x77.
REQ-034: Push/pop 20 characters 0x10..0x23 keeping COUNT between 1 and 3 -> pointers wrap twice, output order exact.
REQ-035: Assert reset low with COUNT=5 between clock edges -> COUNT=0, EMPTY=1, RD_VALID=0, RD_DATA=0 immediately; OVERRUN_CLR=1 with OVERRUN=1 -> OVERRUN=0 next edge.
